mux_sel_stream: RTL and testbench

- Parametrised N-channel, W-bit registered multiplexer with a valid/ready output stage.
- Generalises the fixed 8:1 single-bit combinational mux in width and channel count.
- Adds an auto-scan mode that round-robins the channels with a programmable dwell.
- Used by the lab datapaths to feed one downstream consumer from several sources. An out-of-range select raises a hardware error flag; nothing is printed.

---
 rtl/mux_sel_stream_if.sv | 28 ++
 rtl/mux_sel_stream.sv | 118 +++++++++++
 tb/tb_mux_sel_stream.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/mux_sel_stream_if.sv
// Bundle of channel inputs, select/control and the valid/ready output beat of mux_sel_stream.
// master drives the sources and consumes the beat; slave is the mux itself.
interface mux_sel_stream_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 8
);
    localparam int SEL_W = $clog2(CHANNELS);

    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]          sel;
    logic                      mode;
    logic                      en;
    logic                      out_ready;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_ch;
    logic                      out_valid;
    logic                      sel_err;

    modport master (
        output in_data, sel, mode, en, out_ready,
        input  out_data, out_ch, out_valid, sel_err
    );

    modport slave (
        input  in_data, sel, mode, en, out_ready,
        output out_data, out_ch, out_valid, sel_err
    );
endinterface

// File: rtl/mux_sel_stream.sv
// N-channel registered mux with a valid/ready output stage and a round-robin scan mode
// that takes DWELL loads from each channel before moving to the next.
//
// state  | meaning
// IDLE   | en low: no loads, a pending beat waits for the consumer
// DIRECT | loads come from the channel named by sel
// SCAN   | loads come from the internal pointer, advanced every DWELL loads
module mux_sel_stream #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 8,
    parameter int DWELL    = 4
) (
    input logic             clk,
    input logic             rst_n,
    mux_sel_stream_if.slave bus
);
    localparam int SEL_W = $clog2(CHANNELS);
    localparam int DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;

    typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] chan [CHANNELS];
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] ptr_cur;
    logic [SEL_W-1:0] ptr_adv;
    logic [SEL_W-1:0] ch;
    logic [DW_W-1:0]  dwell;
    logic [DW_W-1:0]  dwell_cur;
    logic             dwell_last;
    logic             sel_bad;
    logic             free;
    logic             load;
    logic [WIDTH-1:0] data_q;
    logic [SEL_W-1:0] ch_q;
    logic             valid_q;
    logic             err_q;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        assign chan[i] = bus.in_data[i*WIDTH +: WIDTH];
    end

    // With a power-of-two channel count every select code is a real channel.
    if ((2 ** SEL_W) > CHANNELS) begin : g_sel_chk
        assign sel_bad = bus.sel > SEL_W'(CHANNELS - 1);
    end else begin : g_sel_ok
        assign sel_bad = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = IDLE;
        ptr_cur    = '0;
        dwell_cur  = '0;
        ch         = bus.sel;
        if (bus.en) begin
            state_next = bus.mode ? SCAN : DIRECT;
        end
        // Entering scan behaves as if pointer and dwell were both zero.
        if (state == SCAN) begin
            ptr_cur   = ptr;
            dwell_cur = dwell;
        end
        if (bus.mode) begin
            ch = ptr_cur;
        end
    end

    assign free       = !valid_q || bus.out_ready;
    assign load       = bus.en && free && !(!bus.mode && sel_bad);
    assign dwell_last = (dwell_cur == DW_W'(DWELL - 1));
    assign ptr_adv    = (ptr_cur == SEL_W'(CHANNELS - 1)) ? '0 : ptr_cur + SEL_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            ptr     <= '0;
            dwell   <= '0;
        end else begin
            err_q <= bus.en && free && !bus.mode && sel_bad;
            if (load) begin
                data_q  <= chan[ch];
                ch_q    <= ch;
                valid_q <= 1'b1;
            end else if (bus.out_ready) begin
                valid_q <= 1'b0;
            end
            if (!(bus.en && bus.mode)) begin
                ptr   <= '0;
                dwell <= '0;
            end else if (load) begin
                if (dwell_last) begin
                    ptr   <= ptr_adv;
                    dwell <= '0;
                end else begin
                    ptr   <= ptr_cur;
                    dwell <= dwell_cur + DW_W'(1);
                end
            end
        end
    end

    assign bus.out_data  = data_q;
    assign bus.out_ch    = ch_q;
    assign bus.out_valid = valid_q;
    assign bus.sel_err   = err_q;
endmodule

// File: tb/tb_mux_sel_stream.sv
// Scoreboard bench for mux_sel_stream: three instances cover 8 channels (direct/stall),
// 5 channels with DWELL=2 (scan/mode switch) and 6 channels with DWELL=1 (select errors, wrap).
module tb_mux_sel_stream;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mux_sel_stream_if #(.WIDTH(8), .CHANNELS(8)) ia ();
    mux_sel_stream_if #(.WIDTH(8), .CHANNELS(5)) ib ();
    mux_sel_stream_if #(.WIDTH(8), .CHANNELS(6)) ic ();

    mux_sel_stream #(.WIDTH(8), .CHANNELS(8), .DWELL(4)) u_a (.clk(clk), .rst_n(rst_n), .bus(ia));
    mux_sel_stream #(.WIDTH(8), .CHANNELS(5), .DWELL(2)) u_b (.clk(clk), .rst_n(rst_n), .bus(ib));
    mux_sel_stream #(.WIDTH(8), .CHANNELS(6), .DWELL(1)) u_c (.clk(clk), .rst_n(rst_n), .bus(ic));

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [12:0] exp_q[$];
    logic [12:0] got;
    logic [12:0] exp_v;

    function automatic logic [12:0] beat(input logic v, input logic [7:0] d, input logic [2:0] c, input logic e);
        return {v, d, c, e};
    endfunction

    function automatic logic [12:0] snap_a();
        return {ia.out_valid, ia.out_data, ia.out_ch, ia.sel_err};
    endfunction
    function automatic logic [12:0] snap_b();
        return {ib.out_valid, ib.out_data, ib.out_ch, ib.sel_err};
    endfunction
    function automatic logic [12:0] snap_c();
        return {ic.out_valid, ic.out_data, ic.out_ch, ic.sel_err};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        ia.en = 0; ia.mode = 0; ia.sel = 0; ia.out_ready = 0;
        ib.en = 0; ib.mode = 0; ib.sel = 0; ib.out_ready = 0;
        ic.en = 0; ic.mode = 0; ic.sel = 0; ic.out_ready = 0;
        for (int i = 0; i < 8; i++) ia.in_data[i*8 +: 8] = 8'(8'hA0 + i);
        for (int i = 0; i < 5; i++) ib.in_data[i*8 +: 8] = 8'(8'hB0 + i);
        for (int i = 0; i < 6; i++) ic.in_data[i*8 +: 8] = 8'(8'hC0 + i);
        #12;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(beat(0, 8'h00, 3'd0, 0));
            got   = (k == 0) ? snap_a() : (k == 1) ? snap_b() : snap_c();
            exp_v = exp_q.pop_front();
            n_checks++;
            if (got !== exp_v)
                begin n_fail++; $display("FAIL reset inst%0d: got v=%b d=%h ch=%0d err=%b, expected v=%b d=%h ch=%0d err=%b", k, got[12], got[11:4], got[3:1], got[0], exp_v[12], exp_v[11:4], exp_v[3:1], exp_v[0]); end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_direct();
        ia.en = 1; ia.mode = 0; ia.out_ready = 1;
        for (int s = 0; s < 8; s++) begin
            ia.sel = 3'(s);
            exp_q.push_back(beat(1, 8'(8'hA0 + s), 3'(s), 0));
            tick();
            got = snap_a(); exp_v = exp_q.pop_front(); n_checks++;
            if (got !== exp_v)
                begin n_fail++; $display("FAIL direct sel=%0d: got v=%b d=%h ch=%0d err=%b, expected v=%b d=%h ch=%0d err=%b", s, got[12], got[11:4], got[3:1], got[0], exp_v[12], exp_v[11:4], exp_v[3:1], exp_v[0]); end
        end
    endtask

    task automatic test_stall();
        ia.sel = 3;
        exp_q.push_back(beat(1, 8'hA3, 3'd3, 0));
        tick();
        got = snap_a(); exp_v = exp_q.pop_front(); n_checks++;
        if (got !== exp_v)
            begin n_fail++; $display("FAIL stall_load: got v=%b d=%h ch=%0d, expected v=%b d=%h ch=%0d", got[12], got[11:4], got[3:1], exp_v[12], exp_v[11:4], exp_v[3:1]); end
        ia.out_ready = 0; ia.sel = 5;
        for (int k = 0; k < 3; k++) begin
            ia.in_data[5*8 +: 8] = 8'(8'h50 + k);
            ia.in_data[3*8 +: 8] = 8'(8'h30 + k);
            exp_q.push_back(beat(1, 8'hA3, 3'd3, 0));
            tick();
            got = snap_a(); exp_v = exp_q.pop_front(); n_checks++;
            if (got !== exp_v)
                begin n_fail++; $display("FAIL stall_hold cycle %0d: got v=%b d=%h ch=%0d, expected v=%b d=%h ch=%0d", k, got[12], got[11:4], got[3:1], exp_v[12], exp_v[11:4], exp_v[3:1]); end
        end
        ia.in_data[5*8 +: 8] = 8'hA5;
        ia.in_data[3*8 +: 8] = 8'hA3;
        ia.out_ready = 1;
        exp_q.push_back(beat(1, 8'hA5, 3'd5, 0));
        tick();
        got = snap_a(); exp_v = exp_q.pop_front(); n_checks++;
        if (got !== exp_v)
            begin n_fail++; $display("FAIL stall_release: got v=%b d=%h ch=%0d, expected v=%b d=%h ch=%0d", got[12], got[11:4], got[3:1], exp_v[12], exp_v[11:4], exp_v[3:1]); end
    endtask

    task automatic test_en_drop();
        logic [3:0] en_t  = 4'b1000;
        logic [3:0] rdy_t = 4'b1011;
        logic [12:0] exp_t [4];
        exp_t[0] = beat(1, 8'hA2, 3'd2, 0);
        exp_t[1] = beat(1, 8'hA2, 3'd2, 0);
        exp_t[2] = beat(0, 8'hA2, 3'd2, 0);
        exp_t[3] = beat(0, 8'hA2, 3'd2, 0);
        ia.sel = 2;
        for (int k = 0; k < 4; k++) begin
            ia.en = en_t[3-k]; ia.out_ready = rdy_t[3-k];
            if (k > 0) ia.sel = 6;
            exp_q.push_back(exp_t[k]);
            tick();
            got = snap_a(); exp_v = exp_q.pop_front(); n_checks++;
            if (got !== exp_v)
                begin n_fail++; $display("FAIL en_drop step %0d: got v=%b d=%h ch=%0d, expected v=%b d=%h ch=%0d", k, got[12], got[11:4], got[3:1], exp_v[12], exp_v[11:4], exp_v[3:1]); end
        end
    endtask

    task automatic test_scan();
        int seq [12] = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 0, 0};
        ib.en = 1; ib.mode = 1; ib.out_ready = 1; ib.sel = 7;
        for (int k = 0; k < 12; k++) begin
            exp_q.push_back(beat(1, 8'(8'hB0 + seq[k]), 3'(seq[k]), 0));
            tick();
            got = snap_b(); exp_v = exp_q.pop_front(); n_checks++;
            if (got !== exp_v)
                begin n_fail++; $display("FAIL scan beat %0d: got v=%b d=%h ch=%0d err=%b, expected v=%b d=%h ch=%0d err=%b", k, got[12], got[11:4], got[3:1], got[0], exp_v[12], exp_v[11:4], exp_v[3:1], exp_v[0]); end
        end
    endtask

    task automatic test_mode_switch();
        int mode_t [10] = '{0, 1, 1, 1, 1, 1, 0, 1, 1, 1};
        int en_t   [10] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        int ch_t   [10] = '{0, 0, 0, 1, 1, 2, 4, 0, 0, 1};
        ib.sel = 4;
        for (int k = 0; k < 10; k++) begin
            ib.en = 1'(en_t[k]); ib.mode = 1'(mode_t[k]);
            exp_q.push_back(beat((k != 0), 8'(8'hB0 + ch_t[k]), 3'(ch_t[k]), 0));
            tick();
            got = snap_b(); exp_v = exp_q.pop_front(); n_checks++;
            if (got !== exp_v)
                begin n_fail++; $display("FAIL mode_switch step %0d: got v=%b d=%h ch=%0d, expected v=%b d=%h ch=%0d", k, got[12], got[11:4], got[3:1], exp_v[12], exp_v[11:4], exp_v[3:1]); end
        end
    endtask

    task automatic test_sel_err();
        int en_t  [7] = '{1, 1, 1, 1, 1, 1, 0};
        int sel_t [7] = '{7, 2, 6, 5, 7, 7, 7};
        int rdy_t [7] = '{1, 1, 1, 1, 0, 1, 1};
        logic [12:0] exp_t [7];
        exp_t[0] = beat(0, 8'h00, 3'd0, 1);
        exp_t[1] = beat(1, 8'hC2, 3'd2, 0);
        exp_t[2] = beat(0, 8'hC2, 3'd2, 1);
        exp_t[3] = beat(1, 8'hC5, 3'd5, 0);
        exp_t[4] = beat(1, 8'hC5, 3'd5, 0);
        exp_t[5] = beat(0, 8'hC5, 3'd5, 1);
        exp_t[6] = beat(0, 8'hC5, 3'd5, 0);
        ic.mode = 0;
        for (int k = 0; k < 7; k++) begin
            ic.en = 1'(en_t[k]); ic.sel = 3'(sel_t[k]); ic.out_ready = 1'(rdy_t[k]);
            exp_q.push_back(exp_t[k]);
            tick();
            got = snap_c(); exp_v = exp_q.pop_front(); n_checks++;
            if (got !== exp_v)
                begin n_fail++; $display("FAIL sel_err step %0d: got v=%b d=%h ch=%0d err=%b, expected v=%b d=%h ch=%0d err=%b", k, got[12], got[11:4], got[3:1], got[0], exp_v[12], exp_v[11:4], exp_v[3:1], exp_v[0]); end
        end
    endtask

    task automatic test_scan_wrap();
        int seq [8] = '{0, 1, 2, 3, 4, 5, 0, 1};
        ic.en = 1; ic.mode = 1; ic.out_ready = 1;
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back(beat(1, 8'(8'hC0 + seq[k]), 3'(seq[k]), 0));
            tick();
            got = snap_c(); exp_v = exp_q.pop_front(); n_checks++;
            if (got !== exp_v)
                begin n_fail++; $display("FAIL scan_wrap beat %0d: got v=%b d=%h ch=%0d, expected v=%b d=%h ch=%0d", k, got[12], got[11:4], got[3:1], exp_v[12], exp_v[11:4], exp_v[3:1]); end
        end
    endtask

    task automatic test_async_reset();
        ia.en = 1; ia.mode = 0; ia.sel = 6; ia.out_ready = 1;
        ic.en = 1; ic.mode = 0; ic.sel = 7; ic.out_ready = 1;
        ib.en = 1; ib.mode = 1; ib.out_ready = 1;
        exp_q.push_back(beat(1, 8'hA6, 3'd6, 0));
        exp_q.push_back(beat(0, 8'hC1, 3'd1, 1));
        tick();
        for (int k = 0; k < 2; k++) begin
            got = (k == 0) ? snap_a() : snap_c(); exp_v = exp_q.pop_front(); n_checks++;
            if (got !== exp_v)
                begin n_fail++; $display("FAIL pre_reset inst%0d: got v=%b d=%h ch=%0d err=%b, expected v=%b d=%h ch=%0d err=%b", k, got[12], got[11:4], got[3:1], got[0], exp_v[12], exp_v[11:4], exp_v[3:1], exp_v[0]); end
        end
        #3;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(beat(0, 8'h00, 3'd0, 0));
            got = (k == 0) ? snap_a() : (k == 1) ? snap_b() : snap_c();
            exp_v = exp_q.pop_front(); n_checks++;
            if (got !== exp_v)
                begin n_fail++; $display("FAIL async_reset inst%0d: got v=%b d=%h ch=%0d err=%b, expected v=%b d=%h ch=%0d err=%b", k, got[12], got[11:4], got[3:1], got[0], exp_v[12], exp_v[11:4], exp_v[3:1], exp_v[0]); end
        end
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(beat(1, (k == 2) ? 8'hB1 : 8'hB0, (k == 2) ? 3'd1 : 3'd0, 0));
            tick();
            got = snap_b(); exp_v = exp_q.pop_front(); n_checks++;
            if (got !== exp_v)
                begin n_fail++; $display("FAIL scan_restart beat %0d: got v=%b d=%h ch=%0d, expected v=%b d=%h ch=%0d", k, got[12], got[11:4], got[3:1], exp_v[12], exp_v[11:4], exp_v[3:1]); end
        end
    endtask

    initial begin
        test_reset();
        test_direct();
        test_stall();
        test_en_drop();
        test_scan();
        test_mode_switch();
        test_sel_err();
        test_scan_wrap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks done, expected completion", n_checks);
        $fatal(1, "timeout");
    end
endmodule
